// File: rtl/lc3b_types.sv
// Shared LC-3b cache types plus the L1->L2 arbiter state encoding.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_cache_line;

  typedef enum logic [1:0] {ARB_IDLE, ARB_OWN_I, ARB_OWN_D} l2_arb_state_t;

  localparam int L2_OFFSET_BITS = 4;

endpackage

// File: rtl/l2_arbiter_if.sv
// L1 I/D request ports and the shared L2 line port seen by l2_arbiter.
interface l2_arbiter_if;
  import lc3b_types::*;

  lc3b_word       i_address, d_address, l2_address;
  logic           i_read, i_write, i_resp;
  logic           d_read, d_write, d_resp;
  lc3b_cache_line i_wdata, i_rdata, d_wdata, d_rdata, l2_wdata, l2_rdata;
  logic           l2_read, l2_write, l2_mem_resp;
  logic           grant_i, grant_d;

  modport slave (
    input  i_address, i_read, i_write, i_wdata,
    input  d_address, d_read, d_write, d_wdata,
    output i_resp, i_rdata, d_resp, d_rdata,
    output l2_address, l2_read, l2_write, l2_wdata,
    input  l2_mem_resp, l2_rdata,
    output grant_i, grant_d
  );

  modport master (
    output i_address, i_read, i_write, i_wdata,
    output d_address, d_read, d_write, d_wdata,
    input  i_resp, i_rdata, d_resp, d_rdata,
    input  l2_address, l2_read, l2_write, l2_wdata,
    output l2_mem_resp, l2_rdata,
    input  grant_i, grant_d
  );
endinterface

// File: rtl/l2_arb_mux.sv
// Combinational steering of the owning L1 side onto the L2 line port.
module l2_arb_mux
  import lc3b_types::*;
#(
  parameter int OFFSET_BITS = L2_OFFSET_BITS
) (
  input  logic           i_sel_i,
  input  logic           i_sel_d,
  input  lc3b_word       i_addr_i,
  input  lc3b_word       i_addr_d,
  input  lc3b_cache_line i_wdata_i,
  input  lc3b_cache_line i_wdata_d,
  input  logic           i_rd_i,
  input  logic           i_wr_i,
  input  logic           i_rd_d,
  input  logic           i_wr_d,
  output lc3b_word       o_address,
  output lc3b_cache_line o_wdata,
  output logic           o_read,
  output logic           o_write
);

  localparam lc3b_word LINE_MASK = ~lc3b_word'((16'd1 << OFFSET_BITS) - 16'd1);

  always_comb begin
    o_address = '0;
    o_wdata   = '0;
    o_read    = 1'b0;
    o_write   = 1'b0;
    // Write takes precedence when a requester raises both strobes.
    if (i_sel_i) begin
      o_address = i_addr_i & LINE_MASK;
      o_wdata   = i_wdata_i;
      o_write   = i_wr_i;
      o_read    = i_rd_i & ~i_wr_i;
    end else if (i_sel_d) begin
      o_address = i_addr_d & LINE_MASK;
      o_wdata   = i_wdata_d;
      o_write   = i_wr_d;
      o_read    = i_rd_d & ~i_wr_d;
    end
  end

endmodule

// File: rtl/l2_arbiter.sv
// Two-way L1 I/D arbiter for the single L2 line port; grant held until l2_mem_resp.
// Tie policy: fixed D-priority, or round-robin when L2_ARB_RR_EN is defined.
module l2_arbiter
  import lc3b_types::*;
#(
  parameter int OFFSET_BITS = L2_OFFSET_BITS
) (
  input  logic         clk,
  input  logic         reset,
  l2_arbiter_if.slave  bus
);

  l2_arb_state_t r_state, w_next;
  logic          w_i_req, w_d_req, w_own_i, w_own_d;

  assign w_i_req = bus.i_read | bus.i_write;
  assign w_d_req = bus.d_read | bus.d_write;
  assign w_own_i = (r_state == ARB_OWN_I);
  assign w_own_d = (r_state == ARB_OWN_D);

`ifdef L2_ARB_RR_EN
  logic r_last_d;  // 1: D held the most recent grant

  always_ff @(posedge clk) begin
    if (reset)
      r_last_d <= 1'b1;
    else if (r_state == ARB_IDLE && w_next != ARB_IDLE)
      r_last_d <= (w_next == ARB_OWN_D);
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= ARB_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ARB_IDLE: begin
`ifdef L2_ARB_RR_EN
        if (w_i_req && w_d_req) w_next = r_last_d ? ARB_OWN_I : ARB_OWN_D;
        else if (w_d_req)       w_next = ARB_OWN_D;
        else if (w_i_req)       w_next = ARB_OWN_I;
`else
        if (w_d_req)      w_next = ARB_OWN_D;
        else if (w_i_req) w_next = ARB_OWN_I;
`endif
      end
      ARB_OWN_I: if (bus.l2_mem_resp) w_next = ARB_IDLE;
      ARB_OWN_D: if (bus.l2_mem_resp) w_next = ARB_IDLE;
      default:   w_next = ARB_IDLE;
    endcase
  end

  // L2 strobes depend only on state and requester inputs, never on l2_mem_resp.
  l2_arb_mux #(.OFFSET_BITS(OFFSET_BITS)) u_mux (
    .i_sel_i   (w_own_i),
    .i_sel_d   (w_own_d),
    .i_addr_i  (bus.i_address),
    .i_addr_d  (bus.d_address),
    .i_wdata_i (bus.i_wdata),
    .i_wdata_d (bus.d_wdata),
    .i_rd_i    (bus.i_read),
    .i_wr_i    (bus.i_write),
    .i_rd_d    (bus.d_read),
    .i_wr_d    (bus.d_write),
    .o_address (bus.l2_address),
    .o_wdata   (bus.l2_wdata),
    .o_read    (bus.l2_read),
    .o_write   (bus.l2_write)
  );

  assign bus.grant_i = w_own_i;
  assign bus.grant_d = w_own_d;
  assign bus.i_resp  = w_own_i & bus.l2_mem_resp;
  assign bus.d_resp  = w_own_d & bus.l2_mem_resp;
  assign bus.i_rdata = bus.l2_rdata;
  assign bus.d_rdata = bus.l2_rdata;

endmodule

// File: doc/l2_arbiter.md
Name: l2_arbiter

Overview:
- Shares the single L1→L2 cache-line port between the instruction-side and data-side L1 miss/writeback engines.
- Grants one requester at a time and holds the grant for the whole L2 transaction, until l2_mem_resp.
- Sits between the two L1 cache controllers and l2_cache; steers address/wdata/read/write down and resp/rdata back.

Parameters:
- OFFSET_BITS, 4, low address bits forced to zero on the forwarded L2 address (16-byte line).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- i_address  in  16 (lc3b_word)  I-side line address
- i_read  in  1  I-side line read request, held until i_resp
- i_write  in  1  I-side line write request, held until i_resp
- i_wdata  in  128 (lc3b_cache_line)  I-side writeback data
- i_resp  out  1  I-side transaction complete
- i_rdata  out  128  I-side read data
- d_address, d_read, d_write, d_wdata, d_resp, d_rdata  same as I-side, for the D-side
- l2_address  out  16  forwarded line address
- l2_read  out  1  forwarded read
- l2_write  out  1  forwarded write
- l2_wdata  out  128  forwarded write data
- l2_mem_resp  in  1  L2 transaction complete
- l2_rdata  in  128  L2 read data
- grant_i, grant_d  out  1 each  current owner, for debug/perf

Behaviour:
- State machine: IDLE, OWN_I, OWN_D. Reset → IDLE.
- Reset value of every output is 0: l2_read/l2_write/l2_address/l2_wdata, i_resp, d_resp, grant_i/grant_d.
- In IDLE:
  - Requester active = read|write.
  - Winner decided combinationally; state moves to OWN_x at the next edge.
  - No L2 signals are driven in IDLE, so there is 1 cycle of arbitration latency.
- In OWN_x:
  - l2_address = x_address with [OFFSET_BITS-1:0] zeroed.
  - l2_wdata = x_wdata.
  - l2_write = x_write; l2_read = x_read & ~x_write (write wins if both asserted).
  - grant_x = 1.
- Response routing:
  - x_resp = l2_mem_resp while in OWN_x; the other side's resp is always 0.
  - i_rdata and d_rdata both carry l2_rdata unconditionally.
- Completion: l2_mem_resp in OWN_x → IDLE at the next edge.
  - Requester drops its request on the cycle after resp, so IDLE never re-grants a completed request.
  - Back-to-back transactions therefore cost exactly 1 idle cycle.
- Owner drops its request before l2_mem_resp (protocol violation): remain in OWN_x with L2 lines following the inputs, i.e. deasserted. Return to IDLE only on l2_mem_resp. No abandonment logic.
- l2_mem_resp while in IDLE: ignored, no resp forwarded.
- Simultaneous requests in IDLE: resolved by the priority policy (see Optional Feature). The loser's request stays held and is granted after the owner's resp plus 1 cycle.
- Reset asserted mid-transaction: next edge → IDLE, all outputs 0. The in-flight L2 transaction is abandoned; l2_cache is reset on the same signal.
- No combinational path from l2_mem_resp to l2_read/l2_write.

Optional Feature:
- Macro: L2_ARB_RR_EN.
- Defined: round-robin priority.
  - 1-bit last_owner register, reset to D, so I wins the first tie.
  - On a tie, grant the side that is not last_owner.
  - last_owner updates on each grant.
- Undefined: fixed priority, D-side always wins ties. The I-side may be delayed indefinitely by continuous D traffic, which is acceptable since a D miss stalls the pipeline.

Decomposition:
- lc3b_types already supplies lc3b_word and lc3b_cache_line.
- Add to lc3b_types: an enum l2_arb_state_t {ARB_IDLE, ARB_OWN_I, ARB_OWN_D}.
- Add to lc3b_types: a localparam for the default line offset width (4).
- One sub-module, l2_arb_mux: combinational 2:1 steering of address/wdata/read/write, selected by owner. The FSM and priority logic stay in l2_arbiter.

Test Plan:
- I-read alone: i_read=1, i_address=0x1236, L2 resp after 5 cycles → l2_address=0x1230, l2_read=1 for 5 cycles starting 1 cycle after request; i_resp pulses 1 cycle with i_rdata=l2_rdata; d_resp stays 0.
- D-write alone: d_write=1, d_wdata=128'hA5…, resp after 3 cycles → l2_write=1, l2_wdata matches, l2_read=0; d_resp pulses once.
- Tie, fixed priority (macro off): i_read and d_read both asserted at cycle 0 → D owns first; I granted exactly 1 cycle after d_resp; two resp pulses total, in order D then I.
- Tie, round-robin (macro on): three consecutive simultaneous-tie rounds, all requests re-asserted immediately → grant order I, D, I.
- Reset mid-transaction: reset during OWN_D, cycle 2 of 5 → next cycle all outputs 0, state IDLE; a later l2_mem_resp produces no d_resp.
- Read+write both asserted on D-side → l2_write=1, l2_read=0.
